// File: rtl/demux3_32b_buf.sv
// 1-to-3 registered distributor: a 32-bit word stream is steered by a 2-bit
// control to one of three single-entry output buffers with valid/ready handshake.
module demux3_32b_buf #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       control,
   output logic [WIDTH-1:0] out0,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [2:0]       out_valid,
   input  logic [2:0]       out_ready,
   output logic [CNT_W-1:0] xfer_count,
   output logic             sel_err
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } chan_state_t;

   logic [2:0]       w_sel_onehot;
   logic             w_sel_legal;
   logic             w_dest_free;
   logic             w_accept;
   logic [2:0]       w_drain;
   logic [1:0]       w_drain_cnt;
   logic [CNT_W-1:0] r_count;
   logic             r_sel_err;

   always_comb begin
      w_sel_onehot = 3'b000;
      case (control)
         2'b00:   w_sel_onehot = 3'b001;
         2'b01:   w_sel_onehot = 3'b010;
         2'b10:   w_sel_onehot = 3'b100;
         default: w_sel_onehot = 3'b000;
      endcase
   end

   // A full destination can still take a word when it drains in the same cycle.
   assign w_sel_legal = (control != 2'b11);
   assign w_dest_free = |(w_sel_onehot & (~out_valid | out_ready));
   assign in_ready    = reset & w_sel_legal & w_dest_free;
   assign w_accept    = in_valid & in_ready;
   assign w_drain     = out_valid & out_ready;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_chan
         chan_state_t      r_state;
         chan_state_t      w_state_next;
         logic             w_load;
         logic [WIDTH-1:0] r_data;

         always_ff @(posedge clock) begin
            if (!reset) begin
               r_state <= ST_EMPTY;
               r_data  <= '0;
            end else begin
               r_state <= w_state_next;
               if (w_load) begin
                  r_data <= in_data;
               end
            end
         end

         always_comb begin
            w_state_next = r_state;
            w_load       = w_accept & w_sel_onehot[gi];
            case (r_state)
               ST_EMPTY: if (w_load) w_state_next = ST_FULL;
               ST_FULL:  if (w_drain[gi] && !w_load) w_state_next = ST_EMPTY;
               default:  w_state_next = ST_EMPTY;
            endcase
         end

         assign out_valid[gi] = (r_state == ST_FULL);
      end
   endgenerate

   assign out0 = g_chan[0].r_data;
   assign out1 = g_chan[1].r_data;
   assign out2 = g_chan[2].r_data;

   assign w_drain_cnt = {1'b0, w_drain[0]} + {1'b0, w_drain[1]} + {1'b0, w_drain[2]};

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_count   <= '0;
         r_sel_err <= 1'b0;
      end else begin
         r_count <= r_count + {{(CNT_W-2){1'b0}}, w_drain_cnt};
         if (in_valid && !w_sel_legal) begin
            r_sel_err <= 1'b1;
         end
      end
   end

   assign xfer_count = r_count;
   assign sel_err    = r_sel_err;

endmodule

// File: tb/tb_demux3_32b_buf.sv
// Directed bench for demux3_32b_buf: accepted words are queued per channel and a
// negedge monitor checks every delivered word; directed checks cover the rest.
module tb_demux3_32b_buf;

   logic        clock;
   logic        reset;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  control;
   logic [31:0] out0;
   logic [31:0] out1;
   logic [31:0] out2;
   logic [2:0]  out_valid;
   logic [2:0]  out_ready;
   logic [7:0]  xfer_count;
   logic        sel_err;

   int checks = 0;
   int errors = 0;

   logic [31:0] q0[$];
   logic [31:0] q1[$];
   logic [31:0] q2[$];

   demux3_32b_buf #(.WIDTH(32), .CNT_W(8)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .control    (control),
      .out0       (out0),
      .out1       (out1),
      .out2       (out2),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .xfer_count (xfer_count),
      .sel_err    (sel_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   // Delivered-word monitor: one line per word taken by a consumer.
   always @(negedge clock) begin
      if (reset) begin
         if (out_valid[0] && out_ready[0]) begin
            if (q0.size() == 0) begin
               checks++; errors++;
               $display("FAIL out0_unexpected: got 0x%08h, required no word", out0);
            end else chk("out0_word", out0, q0.pop_front());
         end
         if (out_valid[1] && out_ready[1]) begin
            if (q1.size() == 0) begin
               checks++; errors++;
               $display("FAIL out1_unexpected: got 0x%08h, required no word", out1);
            end else chk("out1_word", out1, q1.pop_front());
         end
         if (out_valid[2] && out_ready[2]) begin
            if (q2.size() == 0) begin
               checks++; errors++;
               $display("FAIL out2_unexpected: got 0x%08h, required no word", out2);
            end else chk("out2_word", out2, q2.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] d, input logic [1:0] c);
      case (c)
         2'd0:    q0.push_back(d);
         2'd1:    q1.push_back(d);
         default: q2.push_back(d);
      endcase
   endtask

   // Holds the offered word until accepted (bounded), then drops in_valid.
   task automatic accept_wait(input int budget);
      int n;
      n = 0;
      forever begin
         @(negedge clock);
         if (in_ready) begin
            push_exp(in_data, control);
            break;
         end
         n++;
         if (n >= budget) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, required 1", n);
            break;
         end
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic send(input logic [31:0] d, input logic [1:0] c);
      in_data  = d;
      control  = c;
      in_valid = 1'b1;
      accept_wait(8);
   endtask

   initial begin
      reset     = 1'b0;
      in_data   = 32'h0;
      in_valid  = 1'b0;
      control   = 2'b00;
      out_ready = 3'b000;
      tick();
      tick();
      @(negedge clock);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
      chk("rst_out_valid", {29'b0, out_valid}, 32'd0);
      chk("rst_count", {24'b0, xfer_count}, 32'd0);
      chk("rst_sel_err", {31'b0, sel_err}, 32'd0);
      chk("rst_out0", out0, 32'd0);
      tick();
      reset = 1'b1;

      // 1: one word per channel, each drained the cycle after it lands
      out_ready = 3'b111;
      send(32'h5555_5555, 2'd0);
      chk("t1_valid_ch0", {29'b0, out_valid}, 32'b001);
      send(32'h0000_FFFF, 2'd1);
      chk("t1_valid_ch1", {29'b0, out_valid}, 32'b010);
      send(32'hFFFF_0000, 2'd2);
      chk("t1_valid_ch2", {29'b0, out_valid}, 32'b100);
      tick();
      chk("t1_count", {24'b0, xfer_count}, 32'd3);

      // 2: backpressure on channel 1
      out_ready = 3'b101;
      send(32'h0000_000A, 2'd1);
      in_data  = 32'h0000_000B;
      control  = 2'd1;
      in_valid = 1'b1;
      @(negedge clock);
      chk("t2_blocked", {31'b0, in_ready}, 32'd0);
      chk("t2_hold_a", out1, 32'h0000_000A);
      tick();
      chk("t2_hold_a2", out1, 32'h0000_000A);
      chk("t2_valid_held", {29'b0, out_valid}, 32'b010);
      out_ready = 3'b111;
      accept_wait(4);
      chk("t2_out1_b", out1, 32'h0000_000B);
      chk("t2_valid_b", {29'b0, out_valid}, 32'b010);
      tick();
      chk("t2_count", {24'b0, xfer_count}, 32'd5);

      // 3: drain and refill channel 0 in the same cycle
      out_ready = 3'b000;
      send(32'h0000_0001, 2'd0);
      out_ready = 3'b001;
      send(32'h0000_000C, 2'd0);
      chk("t3_valid_kept", {29'b0, out_valid}, 32'b001);
      chk("t3_out0_c", out0, 32'h0000_000C);
      chk("t3_count", {24'b0, xfer_count}, 32'd6);
      tick();
      chk("t3_count2", {24'b0, xfer_count}, 32'd7);

      // 4: illegal select is refused and latches sel_err
      in_data  = 32'hDEAD_BEEF;
      control  = 2'b11;
      in_valid = 1'b1;
      @(negedge clock);
      chk("t4_ready", {31'b0, in_ready}, 32'd0);
      tick();
      chk("t4_valid", {29'b0, out_valid}, 32'd0);
      chk("t4_sel_err", {31'b0, sel_err}, 32'd1);
      control  = 2'b00;
      in_valid = 1'b0;
      tick();
      tick();
      chk("t4_sel_err_sticky", {31'b0, sel_err}, 32'd1);

      // 5: stream up to 254, then three simultaneous drains wrap to 1
      for (int i = 0; i < 247; i++) send(32'h1000_0000 + 32'(i), 2'd0);
      tick();
      chk("t5_count_254", {24'b0, xfer_count}, 32'd254);
      out_ready = 3'b000;
      send(32'hAAAA_0000, 2'd0);
      send(32'hBBBB_1111, 2'd1);
      send(32'hCCCC_2222, 2'd2);
      chk("t5_all_full", {29'b0, out_valid}, 32'b111);
      chk("t5_count_hold", {24'b0, xfer_count}, 32'd254);
      out_ready = 3'b111;
      tick();
      chk("t5_count_wrap", {24'b0, xfer_count}, 32'd1);
      chk("t5_all_empty", {29'b0, out_valid}, 32'd0);
      chk("t5_out2_kept", out2, 32'hCCCC_2222);

      // 6: reset discards buffered words
      out_ready = 3'b000;
      send(32'h0000_0011, 2'd0);
      send(32'h0000_0022, 2'd1);
      chk("t6_valid_011", {29'b0, out_valid}, 32'b011);
      control = 2'd2;
      reset   = 1'b0;
      @(negedge clock);
      chk("t6_ready_in_rst", {31'b0, in_ready}, 32'd0);
      tick();
      q0.delete();
      q1.delete();
      chk("t6_valid", {29'b0, out_valid}, 32'd0);
      chk("t6_out0", out0, 32'd0);
      chk("t6_out1", out1, 32'd0);
      chk("t6_count", {24'b0, xfer_count}, 32'd0);
      chk("t6_sel_err", {31'b0, sel_err}, 32'd0);
      reset = 1'b1;

      out_ready = 3'b111;
      send(32'h7777_7777, 2'd2);
      tick();
      chk("t6_recover_count", {24'b0, xfer_count}, 32'd1);

      tick();
      chk("queues_empty", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
